// File: rtl/cr_phase_timer_if.sv
// Bus between the country-road light controller and its phase timer.
// The controller drives the LED code and raw sensor; the timer returns the grant request, expiry pulse and countdown.
interface cr_phase_timer_if #(
    parameter int CNT_W = 8
);
    // CR_Ena is a level request that holds until the controller answers by showing green;
    // time_out is a one-cycle strobe and has no acknowledge.
    logic             car_sense;
    logic [2:0]       CR_LED;
    logic             CR_Ena;
    logic             time_out;
    logic [CNT_W-1:0] remaining;

    modport master (
        output car_sense,
        output CR_LED,
        input  CR_Ena,
        input  time_out,
        input  remaining
    );

    modport slave (
        input  car_sense,
        input  CR_LED,
        output CR_Ena,
        output time_out,
        output remaining
    );
endinterface

// File: rtl/cr_phase_timer.sv
// Phase timer for the country-road light controller: follows the LED code, counts each phase down
// in prescaled ticks, pulses time_out on expiry and raises a registered grant request for waiting cars.
module cr_phase_timer #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int GREEN_TIME   = 10,
    parameter int YELLOW_TIME  = 3,
    parameter int MIN_RED_TIME = 20,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    cr_phase_timer_if.slave    bus,
    output logic [1:0]         o_dbg_phase
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        PH_RED    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2
    } phase_t;

    phase_t           r_ph;
    phase_t           w_dec;
    phase_t           w_ph_nxt;
    logic             w_load;
    logic [CNT_W-1:0] w_load_time;
    logic             w_tick;

    logic [PW-1:0]    r_presc;
    logic [CNT_W-1:0] r_rem;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_req;
    logic             r_ena;
    logic             r_to;

    // Unknown LED codes fall back to RED so a glitching controller never extends green.
    always_comb begin
        w_dec       = PH_RED;
        w_load_time = CNT_W'(MIN_RED_TIME);
        case (bus.CR_LED)
            3'b100:  w_dec = PH_GREEN;
            3'b010:  w_dec = PH_YELLOW;
            default: w_dec = PH_RED;
        endcase
        case (w_dec)
            PH_GREEN:  w_load_time = CNT_W'(GREEN_TIME);
            PH_YELLOW: w_load_time = CNT_W'(YELLOW_TIME);
            default:   w_load_time = CNT_W'(MIN_RED_TIME);
        endcase
        w_load   = (w_dec != r_ph);
        w_ph_nxt = r_ph;
        if (w_load) begin
            w_ph_nxt = w_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph <= PH_RED;
        end else begin
            r_ph <= w_ph_nxt;
        end
    end

    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

    // A phase load restarts the prescaler so every phase gets whole ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_rem   <= CNT_W'(MIN_RED_TIME);
        end else if (w_load) begin
            r_presc <= '0;
            r_rem   <= w_load_time;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            if (w_tick && (r_rem != '0)) begin
                r_rem <= r_rem - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.car_sense;
            r_sync2 <= r_sync1;
        end
    end

    // Entering green serves the waiting car, so the clear beats a same-edge sensor set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req <= 1'b0;
        end else if (w_load && (w_dec == PH_GREEN)) begin
            r_req <= 1'b0;
        end else if (r_sync2 && (r_ph != PH_GREEN)) begin
            r_req <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to  <= 1'b0;
            r_ena <= 1'b0;
        end else begin
            r_to  <= (r_ph != PH_RED) && w_tick && (r_rem == CNT_W'(1));
            r_ena <= (r_ph == PH_RED) && (r_rem == '0) && r_req && !w_load;
        end
    end

    assign bus.CR_Ena    = r_ena;
    assign bus.time_out  = r_to;
    assign bus.remaining = r_rem;
    assign o_dbg_phase   = r_ph;

endmodule
